// File: rtl/counter_pkg.sv
// Shared constants for the counter/timer set.
// Provides state encoding and the default counter width.
package counter_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sync_down_counter_jkff_ld.sv
// JK flip-flop with async active-low clear and synchronous parallel load.
// Ports: clk, rst_n, ld/d (load path), j/k (JK inputs), q (state).
module jkff_ld (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (ld) begin
            r_q <= d;
        end else begin
            unique case ({j, k})
                2'b00: r_q <= r_q;
                2'b01: r_q <= 1'b0;
                2'b10: r_q <= 1'b1;
                2'b11: r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter/timer built from JK flip-flops.
// Ports: clk, rst_n, load, load_val, en, auto_reload in; out, tc, busy out.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
);

    logic             r_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_borrow;
    logic             w_count;
    logic             w_at_one;
    logic             w_reload;
    logic             w_ld;
    logic [WIDTH-1:0] w_d;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    assign w_count  = (r_state == ST_RUN) && en && !load;
    assign w_at_one = (w_q == ONE);
    // Reaching the terminal edge in periodic mode jumps straight to the
    // reload value instead of decrementing through zero.
    assign w_reload = w_count && w_at_one && auto_reload;
    assign w_ld     = load || w_reload;
    assign w_d      = load ? load_val : r_reload;

    // Bit i toggles only when every lower bit is zero (borrow ripple).
    always_comb begin
        w_borrow    = '0;
        w_borrow[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_borrow[i] = w_borrow[i-1] & ~w_q[i-1];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jkff_ld u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (w_ld),
            .d     (w_d[g]),
            .j     (w_count & w_borrow[g]),
            .k     (w_count & w_borrow[g]),
            .q     (w_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else if (load) begin
            r_reload <= load_val;
            r_tc     <= 1'b0;
            r_state  <= (load_val != ZERO) ? ST_RUN : ST_IDLE;
        end else if (w_count && w_at_one) begin
            r_tc <= 1'b1;
            if (!auto_reload) begin
                r_state <= ST_IDLE;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign out  = w_q;
    assign tc   = r_tc;
    assign busy = (r_state == ST_RUN);

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Loadable synchronous down-counter/timer. It is the counting-direction complement of the team's JK-based synchronous up-counter.
- Counts from a loaded value down to zero on enabled clock edges.
- Flags terminal count with a one-cycle pulse.
- Optionally auto-reloads, so it can serve as a periodic tick generator or one-shot timer.
- Sits beside the up-counter in the counter/timer lab set; its `tc` output is the event source for downstream sequencing.

Parameters:
- `WIDTH`, default 4: counter width in bits; legal range 2..16.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `load`, input, 1: parallel-load strobe; sampled on `clk` rising edge.
- `load_val`, input, `WIDTH`: value to load; also captured as the reload value.
- `en`, input, 1: count enable; sampled on `clk` rising edge.
- `auto_reload`, input, 1: 1 = periodic mode, 0 = one-shot mode; sampled on the terminal edge.
- `out`, output, `WIDTH`: current count, registered.
- `tc`, output, 1: terminal-count pulse, registered; high for exactly one cycle.
- `busy`, output, 1: 1 while in RUN state.

Behaviour:
- Reset (`rst_n` = 0, asynchronous, takes effect immediately, even mid-count):
  - `out` = 0, `tc` = 0, `busy` = 0.
  - Internal reload register = 0.
  - State = IDLE.
- States:
  - IDLE (`busy` = 0): `out` holds its value; `en` is ignored.
  - RUN (`busy` = 1): counts down on each edge where `en` = 1.
- Priority at each rising edge: `load` > count > hold.
- Load (`load` = 1, any state, regardless of `en`):
  - `out` <= `load_val`; reload register <= `load_val`; `tc` <= 0.
  - State <= RUN if `load_val` != 0, else IDLE.
  - A load during RUN restarts the count; no `tc` is produced.
- Count (RUN, `en` = 1, `load` = 0):
  - `out` > 1: `out` <= `out` - 1; `tc` <= 0.
  - `out` = 1, `auto_reload` = 0: `out` <= 0; `tc` <= 1; state <= IDLE.
  - `out` = 1, `auto_reload` = 1: `out` <= reload register (never passes through 0); `tc` <= 1; stay RUN.
- Hold (RUN with `en` = 0, or IDLE): `out` unchanged; `tc` <= 0.
- `tc` is asserted in the same cycle the terminal value appears on `out`, and is never high two cycles in a row unless reload value = 1 with `en` held high (then `tc` is high every enabled cycle).
- Period in auto-reload mode with reload value N and `en` held high: `tc` every N cycles.
- No wrap-around: the count never goes below 0. `en` while `out` = 0 has no effect.
- Counting path:
  - Bit 0 is a JK flip-flop with J = K = 1.
  - Bit i toggles when bits i-1..0 are all 0 (borrow chain: J = K = AND of inverted lower bits).
  - Load and reload override via the flip-flop's synchronous load input.
- Latency: `load` → `out` valid after 1 edge; terminal edge → `tc` visible after the same edge.

Decomposition:
- Shared package `counter_pkg`:
  - State encoding constants: `ST_IDLE` = 1'b0, `ST_RUN` = 1'b1.
  - Default `WIDTH` constant (4), shared with the up-counter.
- Sub-module `jkff_ld`:
  - JK flip-flop with async active-low clear (`rst_n`) and synchronous parallel-load (`ld`, `d`).
  - Instantiated `WIDTH` times through a generate loop.
  - Priority: `rst_n`, then `ld`, then JK.
- Top level holds the state bit, the reload register, borrow-chain gating and `tc` register. Expected size about 150–220 lines.

Test Plan:
- Reset: assert `rst_n` = 0 mid-count at `out` = 5 → `out`, `tc` and `busy` go to 0 immediately, before the next edge; stay 0 until `load`.
- One-shot: `load_val` = 4, `load` 1 cycle, then `en` = 1, `auto_reload` = 0 → `out` 4,3,2,1,0; `tc` = 1 only in the cycle `out` = 0; `busy` falls with it; `out` stays 0.
- Auto-reload: `load_val` = 3, `en` = 1, `auto_reload` = 1 for 12 cycles → `out` 3,2,1,3,2,1,…; `tc` high every 3rd cycle, coincident with `out` = 3 after a 1; never `out` = 0.
- Enable gaps and priority:
  - `load_val` = 6, toggle `en` 1,0,1,0 → `out` 6,5,5,4,4.
  - `load` = 1 with `en` = 1 and `load_val` = 9 → `out` = 9 (load wins); no `tc`.
- Edge values:
  - `load_val` = 0 → `busy` = 0; `en` has no effect; no `tc`.
  - `load_val` = 1 with `en` = 1 → `tc` the next edge.
  - `WIDTH` = 4, `load_val` = 15 one-shot → 15 down to 0 in 15 cycles; every borrow transition (8→7, 4→3) correct.
